// File: rtl/dpll_phase_filter.sv
// dpll_phase_filter
//   Front end of the DPLL reversive counter. A sequential phase detector pairs
//   rising edges of the reference and DCO feedback, producing one lead/lag vote
//   per pairing. A random-walk filter accumulates the votes and emits a single
//   increment/decrement pulse once K_LIMIT net votes of one sign are collected.
//   A lock flag tracks runs of in-phase pairings.
//
// Ports
//   clk_i        in   single clock, posedge
//   reset_i      in   synchronous, active-high reset
//   enable_i     in   1 = run, 0 = detector/filter/lock held idle
//   ref_i        in   reference, asynchronous to clk_i (2-FF synchronized)
//   fb_i         in   DCO feedback, synchronous to clk_i
//   increment_o  out  1-cycle pulse, feedback lags -> counter +1
//   decrement_o  out  1-cycle pulse, feedback leads -> counter -1
//   lock_o       out  loop locked
module dpll_phase_filter #(
    parameter int K_LIMIT    = 8,
    parameter int WIN_WIDTH  = 8,
    parameter int LOCK_COUNT = 16
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic enable_i,
    input  logic ref_i,
    input  logic fb_i,
    output logic increment_o,
    output logic decrement_o,
    output logic lock_o
);

    // One extra bit so +/-(K_LIMIT-1) fits in two's complement.
    localparam int RW_W = $clog2(K_LIMIT) + 1;
    localparam int LC_W = $clog2(LOCK_COUNT + 1);

    localparam logic [WIN_WIDTH-1:0]   WIN_MAX = '1;
    localparam logic signed [RW_W-1:0] RW_ONE  = RW_W'(1);
    localparam logic signed [RW_W-1:0] RW_POS  = RW_W'(K_LIMIT - 1);
    localparam logic signed [RW_W-1:0] RW_NEG  = RW_W'(1 - K_LIMIT);
    localparam logic [LC_W-1:0]        LC_MAX  = LC_W'(LOCK_COUNT);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_FB,
        WAIT_REF
    } state_e;

    logic ref_s1_q, ref_s1_d;
    logic ref_s2_q, ref_s2_d;
    logic ref_s3_q, ref_s3_d;
    logic fb_q, fb_d;

    state_e                 state_q, state_d;
    logic [WIN_WIDTH-1:0]   win_q, win_d;
    logic                   vote_up_q, vote_up_d;
    logic                   vote_dn_q, vote_dn_d;
    logic                   good_q, good_d;
    logic signed [RW_W-1:0] rw_q, rw_d;
    logic                   inc_q, inc_d;
    logic                   dec_q, dec_d;
    logic [LC_W-1:0]        lock_cnt_q, lock_cnt_d;
    logic                   lock_q, lock_d;

    logic ref_rise;
    logic fb_rise;

    always_comb begin
        // Synchronizer and edge registers run regardless of enable_i so that
        // re-enabling never sees a stale edge.
        ref_s1_d = ref_i;
        ref_s2_d = ref_s1_q;
        ref_s3_d = ref_s2_q;
        fb_d     = fb_i;
        ref_rise = ref_s2_q & ~ref_s3_q;
        fb_rise  = fb_i & ~fb_q;

        // Phase detector
        state_d   = state_q;
        win_d     = win_q;
        vote_up_d = 1'b0;
        vote_dn_d = 1'b0;
        good_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (ref_rise && fb_rise) begin
                    good_d = 1'b1;
                end else if (ref_rise) begin
                    state_d = WAIT_FB;
                    win_d   = '0;
                end else if (fb_rise) begin
                    state_d = WAIT_REF;
                    win_d   = '0;
                end
            end
            WAIT_FB: begin
                if (fb_rise) begin
                    vote_up_d = 1'b1;
                    good_d    = (win_q == '0);
                    // A coincident new reference edge opens the next pairing.
                    if (ref_rise) win_d = '0;
                    else          state_d = IDLE;
                end else if (ref_rise) begin
                    vote_up_d = 1'b1;       // feedback edge missed
                    win_d     = '0;
                end else if (win_q == WIN_MAX) begin
                    vote_up_d = 1'b1;       // timeout
                    state_d   = IDLE;
                end else begin
                    win_d = win_q + 1'b1;
                end
            end
            WAIT_REF: begin
                if (ref_rise) begin
                    vote_dn_d = 1'b1;
                    good_d    = (win_q == '0);
                    if (fb_rise) win_d = '0;
                    else         state_d = IDLE;
                end else if (fb_rise) begin
                    vote_dn_d = 1'b1;
                    win_d     = '0;
                end else if (win_q == WIN_MAX) begin
                    vote_dn_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    win_d = win_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                win_d   = '0;
            end
        endcase

        // Random walk, fed by the registered votes
        rw_d  = rw_q;
        inc_d = 1'b0;
        dec_d = 1'b0;
        if (vote_up_q) begin
            if (rw_q == RW_POS) begin
                inc_d = 1'b1;
                rw_d  = '0;
            end else begin
                rw_d = rw_q + RW_ONE;
            end
        end else if (vote_dn_q) begin
            if (rw_q == RW_NEG) begin
                dec_d = 1'b1;
                rw_d  = '0;
            end else begin
                rw_d = rw_q - RW_ONE;
            end
        end

        // Lock: a good pairing counts up (saturating), any other vote clears.
        lock_cnt_d = lock_cnt_q;
        lock_d     = lock_q;
        if (good_q) begin
            if (lock_cnt_q != LC_MAX) lock_cnt_d = lock_cnt_q + 1'b1;
            lock_d = (lock_cnt_d == LC_MAX);
        end else if (vote_up_q || vote_dn_q) begin
            lock_cnt_d = '0;
            lock_d     = 1'b0;
        end

        if (!enable_i) begin
            state_d    = IDLE;
            win_d      = '0;
            vote_up_d  = 1'b0;
            vote_dn_d  = 1'b0;
            good_d     = 1'b0;
            rw_d       = '0;
            inc_d      = 1'b0;
            dec_d      = 1'b0;
            lock_cnt_d = '0;
            lock_d     = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            ref_s1_q   <= 1'b0;
            ref_s2_q   <= 1'b0;
            ref_s3_q   <= 1'b0;
            fb_q       <= 1'b0;
            state_q    <= IDLE;
            win_q      <= '0;
            vote_up_q  <= 1'b0;
            vote_dn_q  <= 1'b0;
            good_q     <= 1'b0;
            rw_q       <= '0;
            inc_q      <= 1'b0;
            dec_q      <= 1'b0;
            lock_cnt_q <= '0;
            lock_q     <= 1'b0;
        end else begin
            ref_s1_q   <= ref_s1_d;
            ref_s2_q   <= ref_s2_d;
            ref_s3_q   <= ref_s3_d;
            fb_q       <= fb_d;
            state_q    <= state_d;
            win_q      <= win_d;
            vote_up_q  <= vote_up_d;
            vote_dn_q  <= vote_dn_d;
            good_q     <= good_d;
            rw_q       <= rw_d;
            inc_q      <= inc_d;
            dec_q      <= dec_d;
            lock_cnt_q <= lock_cnt_d;
            lock_q     <= lock_d;
        end
    end

    assign increment_o = inc_q;
    assign decrement_o = dec_q;
    assign lock_o      = lock_q;

endmodule

// File: tb/tb_dpll_phase_filter.sv
// Bench for dpll_phase_filter (K_LIMIT=8, WIN_WIDTH=4, LOCK_COUNT=16).
// Stimulus: reference with period P rising at 10+P*p; per-period feedback
// offset and presence come from offs[]/fb_on[].
module tb_dpll_phase_filter;

    localparam int K    = 8;
    localparam int WW   = 4;
    localparam int LC   = 16;
    localparam int WMAX = (1 << WW) - 1;
    localparam int P    = 40;
    localparam int NP   = 128;

    logic clk = 1'b0;
    logic reset_i, enable_i, ref_i, fb_i;
    logic increment_o, decrement_o, lock_o;

    always #5 clk = ~clk;

    dpll_phase_filter #(.K_LIMIT(K), .WIN_WIDTH(WW), .LOCK_COUNT(LC)) dut (
        .clk_i      (clk),
        .reset_i    (reset_i),
        .enable_i   (enable_i),
        .ref_i      (ref_i),
        .fb_i       (fb_i),
        .increment_o(increment_o),
        .decrement_o(decrement_o),
        .lock_o     (lock_o)
    );

    int n_chk = 0;
    int n_pass = 0;

    int offs[NP];
    bit fb_on[NP];
    bit ref_en, rnd_en;
    int t, fb_cnt;

    int mism, n_inc, n_dec, max_w, both_hi, max_rw, w_inc, w_dec;

    // Reference model: pend = 0 none, +1 reference waiting for feedback,
    // -1 feedback waiting for reference; age = cycles waited.
    bit m_s1, m_s2, m_s3, m_fbq, m_good, m_inc, m_dec, m_lock;
    int m_pend, m_age, m_vote, m_rw, m_cnt;
    bit rr, fr, g_n, inc_n, dec_n, lock_n;
    int pend_n, age_n, v_n, rw_n, cnt_n;

    always_comb begin
        rr = m_s2 && !m_s3;
        fr = fb_i && !m_fbq;
        pend_n = m_pend;
        age_n  = m_age;
        v_n    = 0;
        g_n    = 1'b0;
        if (m_pend == 0) begin
            if (rr && fr) g_n = 1'b1;
            else if (rr) begin pend_n = 1;  age_n = 0; end
            else if (fr) begin pend_n = -1; age_n = 0; end
        end else begin
            // own = edge that opened the pairing, other = edge that closes it
            bit own, other;
            own   = (m_pend > 0) ? rr : fr;
            other = (m_pend > 0) ? fr : rr;
            if (other) begin
                v_n = m_pend;
                g_n = (m_age == 0);
                if (own) age_n = 0;
                else     pend_n = 0;
            end else if (own) begin
                v_n   = m_pend;
                age_n = 0;
            end else if (m_age == WMAX) begin
                v_n    = m_pend;
                pend_n = 0;
            end else begin
                age_n = m_age + 1;
            end
        end
        rw_n  = m_rw + m_vote;
        inc_n = 1'b0;
        dec_n = 1'b0;
        if (rw_n == K)  begin inc_n = 1'b1; rw_n = 0; end
        if (rw_n == -K) begin dec_n = 1'b1; rw_n = 0; end
        cnt_n  = m_cnt;
        lock_n = m_lock;
        if (m_good) begin
            cnt_n  = (m_cnt < LC) ? m_cnt + 1 : LC;
            lock_n = (cnt_n >= LC);
        end else if (m_vote != 0) begin
            cnt_n  = 0;
            lock_n = 1'b0;
        end
    end

    always @(posedge clk) begin
        if (reset_i) begin
            m_s1 <= 0; m_s2 <= 0; m_s3 <= 0; m_fbq <= 0;
            m_pend <= 0; m_age <= 0; m_vote <= 0; m_good <= 0;
            m_rw <= 0; m_inc <= 0; m_dec <= 0; m_cnt <= 0; m_lock <= 0;
        end else begin
            m_s1 <= ref_i; m_s2 <= m_s1; m_s3 <= m_s2; m_fbq <= fb_i;
            if (!enable_i) begin
                m_pend <= 0; m_age <= 0; m_vote <= 0; m_good <= 0;
                m_rw <= 0; m_inc <= 0; m_dec <= 0; m_cnt <= 0; m_lock <= 0;
            end else begin
                m_pend <= pend_n; m_age <= age_n; m_vote <= v_n; m_good <= g_n;
                m_rw <= rw_n; m_inc <= inc_n; m_dec <= dec_n;
                m_cnt <= cnt_n; m_lock <= lock_n;
            end
        end
    end

    task automatic clear_stats();
        mism = 0; n_inc = 0; n_dec = 0; max_w = 0; both_hi = 0;
        max_rw = 0; w_inc = 0; w_dec = 0;
    endtask

    // Drive n cycles of stimulus; gather DUT observations and model agreement.
    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            int p, rwv;
            ref_i = ref_en && (t >= 10) && (((t - 10) % P) < (P / 2));
            for (int k = -1; k <= 1; k++) begin
                p = t / P + k;
                if (p >= 0 && p < NP && fb_on[p] && t == 10 + P * p + offs[p]) fb_cnt = 5;
            end
            fb_i = (fb_cnt > 0);
            if (fb_cnt > 0) fb_cnt--;
            if (rnd_en) enable_i = ($urandom_range(0, 149) != 0);
            @(posedge clk);
            @(negedge clk);
            rwv = dut.rw_q;
            if (increment_o !== m_inc || decrement_o !== m_dec ||
                lock_o !== m_lock || rwv !== m_rw) mism++;
            if (increment_o === 1'b1) n_inc++;
            if (decrement_o === 1'b1) n_dec++;
            if (increment_o === 1'b1 && decrement_o === 1'b1) both_hi++;
            w_inc = (increment_o === 1'b1) ? w_inc + 1 : 0;
            w_dec = (decrement_o === 1'b1) ? w_dec + 1 : 0;
            if (w_inc > max_w) max_w = w_inc;
            if (w_dec > max_w) max_w = w_dec;
            if (rwv < 0) rwv = -rwv;
            if (rwv > max_rw) max_rw = rwv;
            t++;
        end
    endtask

    task automatic prep();
        reset_i = 1'b1; enable_i = 1'b1; rnd_en = 1'b0; ref_en = 1'b0;
        fb_cnt = 0; t = 0;
        for (int p = 0; p < NP; p++) begin offs[p] = 0; fb_on[p] = 1'b0; end
        run(3);
        reset_i = 1'b0;
        clear_stats();
        t = 0;
    endtask

    task automatic test_reset();
        int rwv, winv;
        prep();
        n_chk++; if (increment_o !== 1'b0) $display("FAIL rst0_inc: got %b want 0", increment_o); else n_pass++;
        n_chk++; if (decrement_o !== 1'b0) $display("FAIL rst0_dec: got %b want 0", decrement_o); else n_pass++;
        n_chk++; if (lock_o !== 1'b0) $display("FAIL rst0_lock: got %b want 0", lock_o); else n_pass++;
        // five lag pairings -> rw=5, then a lone reference leaves the FSM waiting
        ref_en = 1'b1;
        for (int p = 0; p < NP; p++) begin offs[p] = 3; fb_on[p] = (p != 5); end
        run(5 * P);
        run(16);
        rwv = dut.rw_q;
        n_chk++; if (rwv !== 5) $display("FAIL rst_pre_rw: got %0d want 5", rwv); else n_pass++;
        reset_i = 1'b1;
        run(3);
        reset_i = 1'b0;
        rwv = dut.rw_q;
        winv = int'(dut.win_q);
        n_chk++; if (rwv !== 0) $display("FAIL rst_rw: got %0d want 0", rwv); else n_pass++;
        n_chk++; if (winv !== 0) $display("FAIL rst_win: got %0d want 0", winv); else n_pass++;
        n_chk++; if ({increment_o, decrement_o, lock_o} !== 3'b000)
            $display("FAIL rst_outs: got %b want 000", {increment_o, decrement_o, lock_o}); else n_pass++;
        run(3 * P);
        n_chk++; if (mism !== 0) $display("FAIL rst_model: got %0d mismatching cycles want 0", mism); else n_pass++;
    endtask

    task automatic test_lag();
        prep();
        ref_en = 1'b1;
        for (int p = 0; p < NP; p++) begin offs[p] = 3; fb_on[p] = 1'b1; end
        run(16 * P + 10);
        n_chk++; if (n_inc !== 2) $display("FAIL lag_inc: got %0d pulses want 2", n_inc); else n_pass++;
        n_chk++; if (n_dec !== 0) $display("FAIL lag_dec: got %0d pulses want 0", n_dec); else n_pass++;
        n_chk++; if (max_w !== 1) $display("FAIL lag_width: got %0d want 1", max_w); else n_pass++;
        n_chk++; if (mism !== 0) $display("FAIL lag_model: got %0d mismatching cycles want 0", mism); else n_pass++;
    endtask

    task automatic test_lead();
        prep();
        ref_en = 1'b1;
        for (int p = 0; p < NP; p++) begin offs[p] = -3; fb_on[p] = 1'b1; end
        run(16 * P + 10);
        n_chk++; if (n_dec !== 2) $display("FAIL lead_dec: got %0d pulses want 2", n_dec); else n_pass++;
        n_chk++; if (n_inc !== 0) $display("FAIL lead_inc: got %0d pulses want 0", n_inc); else n_pass++;
        n_chk++; if (max_w !== 1) $display("FAIL lead_width: got %0d want 1", max_w); else n_pass++;
        n_chk++; if (mism !== 0) $display("FAIL lead_model: got %0d mismatching cycles want 0", mism); else n_pass++;
    endtask

    task automatic test_dither();
        prep();
        ref_en = 1'b1;
        for (int p = 0; p < NP; p++) begin offs[p] = (p % 2 == 0) ? 3 : -3; fb_on[p] = 1'b1; end
        run(100 * P + 10);
        n_chk++; if (n_inc + n_dec !== 0) $display("FAIL dither_pulses: got %0d want 0", n_inc + n_dec); else n_pass++;
        n_chk++; if (max_rw > 1) $display("FAIL dither_rw: got max |rw| %0d want <=1", max_rw); else n_pass++;
        n_chk++; if (mism !== 0) $display("FAIL dither_model: got %0d mismatching cycles want 0", mism); else n_pass++;
    endtask

    task automatic test_lock();
        prep();
        ref_en = 1'b1;
        // fb two clocks after ref lines up with the synchronized reference edge
        for (int p = 0; p < NP; p++) begin offs[p] = 2; fb_on[p] = (p <= 16); end
        offs[16] = 7;
        run(15 * P);
        n_chk++; if (lock_o !== 1'b0) $display("FAIL lock_15: got %b want 0", lock_o); else n_pass++;
        run(P);
        n_chk++; if (lock_o !== 1'b1) $display("FAIL lock_16: got %b want 1", lock_o); else n_pass++;
        run(18);
        n_chk++; if (lock_o !== 1'b1) $display("FAIL lock_at_vote: got %b want 1", lock_o); else n_pass++;
        run(1);
        n_chk++; if (lock_o !== 1'b0) $display("FAIL lock_drop: got %b want 0", lock_o); else n_pass++;
        n_chk++; if (mism !== 0) $display("FAIL lock_model: got %0d mismatching cycles want 0", mism); else n_pass++;
    endtask

    task automatic test_missing_fb();
        int rwv;
        prep();
        ref_en = 1'b1;
        run(19 * P);
        rwv = dut.rw_q;
        n_chk++; if (n_inc !== 2) $display("FAIL miss_inc: got %0d pulses want 2", n_inc); else n_pass++;
        n_chk++; if (n_dec !== 0) $display("FAIL miss_dec: got %0d pulses want 0", n_dec); else n_pass++;
        n_chk++; if (rwv !== 3) $display("FAIL miss_rw: got %0d want 3", rwv); else n_pass++;
        enable_i = 1'b0;
        run(1);
        enable_i = 1'b1;
        rwv = dut.rw_q;
        n_chk++; if (rwv !== 0) $display("FAIL miss_en_rw: got %0d want 0", rwv); else n_pass++;
        run(2 * P);
        n_chk++; if (mism !== 0) $display("FAIL miss_model: got %0d mismatching cycles want 0", mism); else n_pass++;
    endtask

    task automatic test_random();
        prep();
        ref_en = 1'b1;
        rnd_en = 1'b1;
        for (int p = 0; p < NP; p++) begin
            offs[p]  = int'($urandom_range(0, 36)) - 20;
            fb_on[p] = ($urandom_range(0, 9) != 0);
        end
        run(60 * P);
        rnd_en = 1'b0;
        enable_i = 1'b1;
        n_chk++; if (both_hi !== 0) $display("FAIL rnd_excl: got %0d overlap cycles want 0", both_hi); else n_pass++;
        n_chk++; if (max_w > 1) $display("FAIL rnd_width: got %0d want <=1", max_w); else n_pass++;
        n_chk++; if (mism !== 0) $display("FAIL rnd_model: got %0d mismatching cycles want 0", mism); else n_pass++;
    endtask

    initial begin
        reset_i = 1'b1; enable_i = 1'b0; ref_i = 1'b0; fb_i = 1'b0;
        ref_en = 1'b0; rnd_en = 1'b0; t = 0; fb_cnt = 0;
        clear_stats();
        @(negedge clk);
        test_reset();
        test_lag();
        test_lead();
        test_dither();
        test_lock();
        test_missing_fb();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
